bt656_decoder: RTL
==================

BT656_DECODER -- requirements
Module: bt656_decoder

Interface
REQ-001 ACTIVE_W, 720, number of luma samples per active line; samples beyond this are dropped.
REQ-002 LINE_W, 10, width of the line counter.
REQ-003 clk  in  1  pixel-byte clock; TD_CLK27 at top level.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_data  in  8  ITU-R BT.656 byte stream, TD_DATA; one byte per clk.
REQ-006 o_pix_valid  out  1  one-cycle strobe; o_y/o_cb/o_cr/o_x hold one active pixel.
REQ-007 o_y, o_cb, o_cr  out  8 each  4:2:2 pixel; chroma is shared by each Y pair.
REQ-008 o_x  out  11  pixel index in line, 0..ACTIVE_W-1.
REQ-009 o_line  out  LINE_W  line index within the current field.
REQ-010 o_field  out  1  F bit of the last accepted timing code.
REQ-011 o_vblank  out  1  V bit of the last accepted timing code.
REQ-012 o_hblank  out  1  high between EAV and SAV.
REQ-013 o_sav, o_eav  out  1 each  one-cycle strobes on accepted timing codes.
REQ-014 o_err  out  1  one-cycle strobe on protocol violation.

Function
REQ-015 The timing-reference FSM SHALL use states DATA, FF, Z1, Z2:
- DATA->FF on 8'hFF.
- FF->Z1 on 8'h00; FF->DATA on any other byte, with o_err.
- Z1->Z2 on 8'h00; Z1->DATA on any other byte, with o_err.
- Z2 always ->DATA; the byte in Z2 is the XY word.
REQ-016 XY decode SHALL be F=bit6, V=bit5, H=bit4; bit7 SHALL be 1, otherwise the code is rejected with o_err.
REQ-017 An accepted XY word SHALL update o_field and o_vblank on the next cycle.
REQ-018 H=0 (SAV) SHALL pulse o_sav, clear o_hblank, and reset the sample phase and o_x to 0.
REQ-019 H=1 (EAV) SHALL pulse o_eav, set o_hblank, and increment o_line, saturating at all-ones.
REQ-020 An F change between consecutive accepted codes SHALL reset o_line to 0 in place of incrementing it.
REQ-021 Active bytes SHALL follow a 2-bit phase Cb, Y0, Cr, Y1, wrapping to Cb.
- Bytes are active only while o_hblank=0, o_vblank=0 and the FSM is in DATA.
- Bytes consumed by FF/Z1/Z2 SHALL NOT advance the phase.
REQ-022 Pixel Y0 SHALL be emitted with that pair's Cb/Cr on the cycle after Cr is received.
REQ-023 Pixel Y1 SHALL be emitted on the cycle after Y1 is received.
REQ-024 o_x SHALL increment after each emitted pixel.
REQ-025 When o_x reaches ACTIVE_W, further active bytes SHALL be dropped with no strobe and a single o_err pulse, until the next SAV.
REQ-026 SAV received while o_hblank=0 (missing EAV) SHALL pulse o_err, then proceed as a normal SAV.
REQ-027 EAV received mid pixel pair SHALL discard the partial pair without emitting it.
REQ-028 o_err SHALL NOT be asserted more than once per clk; simultaneous causes coalesce into one pulse.

Reset
REQ-029 On rst=1 at a clk edge, reset SHALL take effect in that cycle.
- FSM goes to DATA; phase, o_x and o_line go to 0.
- o_hblank=1, o_vblank=1, o_field=0.
- All strobes and pixel outputs go to 0.
REQ-030 Reset mid-line SHALL suppress all pixel output until the next accepted SAV with V=0.

Configuration
REQ-031 With BT656_PROTECT_CHECK_EN defined, the XY word SHALL also be checked.
- Required: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H (bits 3..0).
- On mismatch the code is rejected, the state is unchanged, and o_err pulses.
REQ-032 Without BT656_PROTECT_CHECK_EN, bits 3..0 SHALL be ignored.

Structure
REQ-033 Package bt656_pkg SHALL hold:
- the FSM state enum;
- code byte constants 8'hFF and 8'h00;
- XY bit-position constants;
- the phase enum CB/Y0/CR/Y1.
REQ-034 Sub-module bt656_trs_detect SHALL contain the FSM and XY checking.
- Outputs: code_valid, F, V, H, and a byte-is-data flag to the pixel path.

Verification
REQ-035 Stream FF 00 00 80 (SAV, V=0), then 10 20 30 40 -> o_sav pulse; 2 pixels: (Y=20, Cb=10, Cr=30, x=0), (Y=40, Cb=10, Cr=30, x=1).
REQ-036 Full line of 1440 bytes + extra 4 bytes -> 720 pixels with x 0..719, then exactly one o_err and no further strobes.
REQ-037 FF 12 in active data -> o_err; phase unchanged; the next pixel is still correct.
REQ-038 EAV with F=0 then SAV with F=1 (XY=C7/C0 family) -> o_line resets to 0 and o_field=1.
REQ-039 BT656_PROTECT_CHECK_EN defined, XY=8'h81 (bad P0) -> o_err, no o_sav, state held; undefined -> o_sav accepted.
REQ-040 rst asserted mid-line for 1 cycle -> outputs at reset values next cycle; no pixels until the next SAV.

Source files
------------

// File: rtl/bt656_pkg.sv
// Shared types and constants for the BT.656 decoder.
package bt656_pkg;

  typedef enum logic [1:0] {ST_DATA, ST_FF, ST_Z1, ST_Z2} trs_state_t;
  typedef enum logic [1:0] {PH_CB, PH_Y0, PH_CR, PH_Y1} phase_t;

  localparam logic [7:0] CODE_FF = 8'hFF;
  localparam logic [7:0] CODE_00 = 8'h00;

  localparam int unsigned XY_ONE_BIT = 7;
  localparam int unsigned XY_F_BIT   = 6;
  localparam int unsigned XY_V_BIT   = 5;
  localparam int unsigned XY_H_BIT   = 4;

  localparam int unsigned X_W = 11;

  // Expected protection nibble {P3,P2,P1,P0} for a given F/V/H.
  function automatic logic [3:0] protect_bits(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// Timing-reference (FF 00 00 XY) detector with XY validation.
// Optional protection-bit check enabled by BT656_PROTECT_CHECK_EN.
module bt656_trs_detect
  import bt656_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  output logic       code_valid_c,
  output logic       f_c,
  output logic       v_c,
  output logic       h_c,
  output logic       data_c,
  output logic       err_c
);

  trs_state_t state;
  trs_state_t state_next;
  logic       xy_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_DATA;
    else     state <= state_next;
  end

  // Next state, data/code classification of the current byte.
  always_comb begin
    state_next   = state;
    code_valid_c = 1'b0;
    data_c       = 1'b0;
    err_c        = 1'b0;
    xy_ok        = data[XY_ONE_BIT];
`ifdef BT656_PROTECT_CHECK_EN
    xy_ok = xy_ok && (data[3:0] == protect_bits(data[XY_F_BIT], data[XY_V_BIT], data[XY_H_BIT]));
`endif
    case (state)
      ST_DATA: begin
        if (data == CODE_FF) state_next = ST_FF;
        else                 data_c     = 1'b1;
      end
      ST_FF: begin
        if (data == CODE_00) state_next = ST_Z1;
        else begin
          state_next = ST_DATA;
          err_c      = 1'b1;
        end
      end
      ST_Z1: begin
        if (data == CODE_00) state_next = ST_Z2;
        else begin
          state_next = ST_DATA;
          err_c      = 1'b1;
        end
      end
      ST_Z2: begin
        state_next = ST_DATA;
        if (xy_ok) code_valid_c = 1'b1;
        else       err_c        = 1'b1;
      end
      default: state_next = ST_DATA;
    endcase
  end

  assign f_c = data[XY_F_BIT];
  assign v_c = data[XY_V_BIT];
  assign h_c = data[XY_H_BIT];

endmodule

// File: rtl/bt656_decoder.sv
// BT.656 byte-stream decoder producing 4:2:2 pixels with line/field timing.
// Define BT656_PROTECT_CHECK_EN to reject XY words with bad protection bits.
module bt656_decoder
  import bt656_pkg::*;
#(
  parameter int unsigned ACTIVE_W = 720,
  parameter int unsigned LINE_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_data,
  output logic              o_pix_valid,
  output logic [7:0]        o_y,
  output logic [7:0]        o_cb,
  output logic [7:0]        o_cr,
  output logic [X_W-1:0]    o_x,
  output logic [LINE_W-1:0] o_line,
  output logic              o_field,
  output logic              o_vblank,
  output logic              o_hblank,
  output logic              o_sav,
  output logic              o_eav,
  output logic              o_err
);

  logic code_valid_c, f_c, v_c, h_c, data_c, trs_err_c;
  logic active_c, overflow_c, sav_c, eav_c, err_next_c;

  phase_t         phase;
  logic [X_W-1:0] x_cnt;
  logic           drop_seen;
  logic [7:0]     cb_hold, y0_hold, cr_hold;

  bt656_trs_detect u_trs (
    .clk          (clk),
    .rst          (rst),
    .data         (i_data),
    .code_valid_c (code_valid_c),
    .f_c          (f_c),
    .v_c          (v_c),
    .h_c          (h_c),
    .data_c       (data_c),
    .err_c        (trs_err_c)
  );

  // Classify the current byte and merge all error causes into one pulse.
  always_comb begin
    active_c   = data_c && !o_hblank && !o_vblank;
    overflow_c = active_c && (x_cnt >= X_W'(ACTIVE_W));
    sav_c      = code_valid_c && !h_c;
    eav_c      = code_valid_c && h_c;
    err_next_c = trs_err_c || (sav_c && !o_hblank) || (overflow_c && !drop_seen);
  end

  // Timing state, sample phase and pixel assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= PH_CB;
      x_cnt       <= '0;
      drop_seen   <= 1'b0;
      cb_hold     <= '0;
      y0_hold     <= '0;
      cr_hold     <= '0;
      o_pix_valid <= 1'b0;
      o_y         <= '0;
      o_cb        <= '0;
      o_cr        <= '0;
      o_x         <= '0;
      o_line      <= '0;
      o_field     <= 1'b0;
      o_vblank    <= 1'b1;
      o_hblank    <= 1'b1;
      o_sav       <= 1'b0;
      o_eav       <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_pix_valid <= 1'b0;
      o_sav       <= sav_c;
      o_eav       <= eav_c;
      o_err       <= err_next_c;
      if (code_valid_c) begin
        o_field  <= f_c;
        o_vblank <= v_c;
        phase    <= PH_CB;
        if (f_c != o_field)             o_line <= '0;
        else if (h_c && (o_line != '1)) o_line <= o_line + LINE_W'(1);
        if (h_c) begin
          o_hblank <= 1'b1;
        end else begin
          o_hblank  <= 1'b0;
          x_cnt     <= '0;
          o_x       <= '0;
          drop_seen <= 1'b0;
        end
      end else if (overflow_c) begin
        drop_seen <= 1'b1;
      end else if (active_c) begin
        case (phase)
          PH_CB: begin
            cb_hold <= i_data;
            phase   <= PH_Y0;
          end
          PH_Y0: begin
            y0_hold <= i_data;
            phase   <= PH_CR;
          end
          PH_CR: begin
            cr_hold     <= i_data;
            o_pix_valid <= 1'b1;
            o_y         <= y0_hold;
            o_cb        <= cb_hold;
            o_cr        <= i_data;
            o_x         <= x_cnt;
            x_cnt       <= x_cnt + X_W'(1);
            phase       <= PH_Y1;
          end
          default: begin
            o_pix_valid <= 1'b1;
            o_y         <= i_data;
            o_cb        <= cb_hold;
            o_cr        <= cr_hold;
            o_x         <= x_cnt;
            x_cnt       <= x_cnt + X_W'(1);
            phase       <= PH_CB;
          end
        endcase
      end
    end
  end

endmodule
